fba_seq: RTL and testbench



---
 rtl/fba_seq.sv | 130 +++++++++++++
 tb/tb_fba_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fba_seq.sv
// fba_seq: nibble-serial add/subtract sequencer around one 4-bit ripple adder.
// START/BUSY/DONE handshake; operands registered at accept.
module fba (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];
endmodule

module fba_seq #(
  parameter int NIBBLES = 2
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 START,
  input  logic                 SUB,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] RESULT,
  output logic                 CARRY,
  output logic                 ZERO
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry_reg;
  logic [W-1:0]    sh_a;
  logic [W-1:0]    sh_b;
  logic [W-1:0]    res_nx;
  logic [3:0]      nib_s;
  logic            nib_c;
  logic [IW+1:0]   pos;

  assign pos  = {idx, 2'b00};
  assign sh_a = a_reg >> pos;
  assign sh_b = b_reg >> pos;

  fba u_fba (
    .a    (sh_a[3:0]),
    .b    (sh_b[3:0]),
    .cin  (carry_reg),
    .sum  (nib_s),
    .cout (nib_c)
  );

  // Splice the fresh nibble into the partial result.
  assign res_nx = (RESULT & ~(W'(4'hF) << pos))
                | (W'(nib_s) << pos);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Flags are loaded on the last RUN edge so they are final while DONE is up.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      RESULT    <= '0;
      CARRY     <= 1'b0;
      ZERO      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            a_reg     <= A;
            b_reg     <= SUB ? ~B : B;
            carry_reg <= SUB;
            idx       <= '0;
            RESULT    <= '0;
            CARRY     <= 1'b0;
            ZERO      <= 1'b0;
          end
        end
        RUN: begin
          RESULT    <= res_nx;
          carry_reg <= nib_c;
          if (idx == LAST) begin
            idx   <= '0;
            CARRY <= nib_c;
            ZERO  <= (res_nx == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN:     ;
        default: ;
      endcase
    end
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);
endmodule

// File: tb/tb_fba_seq.sv
// tb_fba_seq: three widths (2, 1, 4 nibbles) checked every cycle
// against a timeline/arithmetic reference model.
module tb_fba_seq;
  localparam int NN [3] = '{2, 1, 4};

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [2:0]  start;
  logic [2:0]  sub;
  logic [31:0] a [3];
  logic [31:0] b [3];
  wire  [2:0]  busy;
  wire  [2:0]  done;
  wire  [2:0]  cy;
  wire  [2:0]  zr;
  wire  [7:0]  r0;
  wire  [3:0]  r1;
  wire  [15:0] r2;

  int checks = 0;
  int errors = 0;

  int          cnt    [3];
  logic [31:0] fin_r  [3];
  logic        fin_c  [3];
  logic        fin_z  [3];
  logic [31:0] disp_r [3];
  logic        disp_c [3];
  logic        disp_z [3];
  logic        valid  [3];

  logic        pin_en [3];
  logic [31:0] pin_r  [3];
  logic        pin_c  [3];
  logic        pin_z  [3];

  always #5 clk = ~clk;

  fba_seq #(.NIBBLES(2)) u0 (
    .CLK(clk), .CLR_N(clr_n), .START(start[0]), .SUB(sub[0]),
    .A(a[0][7:0]), .B(b[0][7:0]), .BUSY(busy[0]), .DONE(done[0]),
    .RESULT(r0), .CARRY(cy[0]), .ZERO(zr[0]));

  fba_seq #(.NIBBLES(1)) u1 (
    .CLK(clk), .CLR_N(clr_n), .START(start[1]), .SUB(sub[1]),
    .A(a[1][3:0]), .B(b[1][3:0]), .BUSY(busy[1]), .DONE(done[1]),
    .RESULT(r1), .CARRY(cy[1]), .ZERO(zr[1]));

  fba_seq #(.NIBBLES(4)) u2 (
    .CLK(clk), .CLR_N(clr_n), .START(start[2]), .SUB(sub[2]),
    .A(a[2][15:0]), .B(b[2][15:0]), .BUSY(busy[2]), .DONE(done[2]),
    .RESULT(r2), .CARRY(cy[2]), .ZERO(zr[2]));

  function automatic logic [31:0] res_of(int i);
    case (i)
      0:       return 32'(r0);
      1:       return 32'(r1);
      default: return 32'(r2);
    endcase
  endfunction

  function automatic logic [31:0] ref_res(logic [31:0] x, logic [31:0] y,
                                          logic s, int n);
    longint unsigned m, xv, yv;
    m  = (64'd1 << (4 * n)) - 64'd1;
    xv = 64'(x) & m;
    yv = 64'(y) & m;
    return s ? 32'((xv - yv) & m) : 32'((xv + yv) & m);
  endfunction

  function automatic logic ref_c(logic [31:0] x, logic [31:0] y,
                                 logic s, int n);
    longint unsigned m, xv, yv;
    m  = (64'd1 << (4 * n)) - 64'd1;
    xv = 64'(x) & m;
    yv = 64'(y) & m;
    return s ? (xv >= yv) : (((xv + yv) >> (4 * n)) != 64'd0);
  endfunction

  // cnt: 0 idle, 1..N busy cycles, N+1 done cycle
  always @(posedge clk or negedge clr_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!clr_n) begin
        cnt[i]    <= 0;
        disp_r[i] <= '0;
        disp_c[i] <= 1'b0;
        disp_z[i] <= 1'b0;
        valid[i]  <= 1'b1;
      end else if (cnt[i] == 0) begin
        if (start[i]) begin
          cnt[i]    <= 1;
          valid[i]  <= 1'b0;
          disp_c[i] <= 1'b0;
          disp_z[i] <= 1'b0;
          fin_r[i]  <= ref_res(a[i], b[i], sub[i], NN[i]);
          fin_c[i]  <= ref_c(a[i], b[i], sub[i], NN[i]);
          fin_z[i]  <= (ref_res(a[i], b[i], sub[i], NN[i]) == 32'd0);
        end
      end else if (cnt[i] == NN[i]) begin
        cnt[i]    <= cnt[i] + 1;
        valid[i]  <= 1'b1;
        disp_r[i] <= fin_r[i];
        disp_c[i] <= fin_c[i];
        disp_z[i] <= fin_z[i];
      end else if (cnt[i] == NN[i] + 1) begin
        cnt[i] <= 0;
      end else begin
        cnt[i] <= cnt[i] + 1;
      end
    end
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t",
               nm, i, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk or negedge clr_n);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!clr_n) begin
        chk("rst_busy", i, 32'(busy[i]), 32'd0);
        chk("rst_done", i, 32'(done[i]), 32'd0);
        chk("rst_result", i, res_of(i), 32'd0);
        chk("rst_carry", i, 32'(cy[i]), 32'd0);
        chk("rst_zero", i, 32'(zr[i]), 32'd0);
      end else begin
        chk("busy", i, 32'(busy[i]),
            32'(cnt[i] >= 1 && cnt[i] <= NN[i]));
        chk("done", i, 32'(done[i]), 32'(cnt[i] == NN[i] + 1));
        if (valid[i]) begin
          chk("result", i, res_of(i), disp_r[i]);
          chk("carry", i, 32'(cy[i]), 32'(disp_c[i]));
          chk("zero", i, 32'(zr[i]), 32'(disp_z[i]));
        end else begin
          chk("carry_run", i, 32'(cy[i]), 32'd0);
          chk("zero_run", i, 32'(zr[i]), 32'd0);
        end
        if (cnt[i] == NN[i] + 1 && pin_en[i]) begin
          chk("pin_result", i, res_of(i), pin_r[i]);
          chk("pin_carry", i, 32'(cy[i]), 32'(pin_c[i]));
          chk("pin_zero", i, 32'(zr[i]), 32'(pin_z[i]));
          chk("model_pin", i, disp_r[i], pin_r[i]);
        end
      end
    end
  end

  task automatic op(int i, logic [31:0] x, logic [31:0] y, logic s,
                    logic [31:0] pr, logic pc, logic pz);
    @(posedge clk);
    #1;
    a[i] = x; b[i] = y; sub[i] = s; start[i] = 1'b1;
    pin_r[i] = pr; pin_c[i] = pc; pin_z[i] = pz; pin_en[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    repeat (NN[i] + 3) @(posedge clk);
    #1;
    pin_en[i] = 1'b0;
  endtask

  initial begin
    start = '0;
    sub   = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0; b[i] = '0; pin_en[i] = 1'b0;
      pin_r[i] = '0; pin_c[i] = 1'b0; pin_z[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (5) @(posedge clk);

    op(0, 32'h3C, 32'h45, 1'b0, 32'h81, 1'b0, 1'b0);
    op(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b1);
    op(0, 32'h50, 32'h20, 1'b1, 32'h30, 1'b1, 1'b0);
    op(0, 32'h20, 32'h50, 1'b1, 32'hD0, 1'b0, 1'b0);
    op(0, 32'h5A, 32'h5A, 1'b1, 32'h00, 1'b1, 1'b1);

    // asynchronous reset mid-cycle with flags set
    @(posedge clk);
    #3 clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (5) @(posedge clk);

    // START and operands toggled while busy must be ignored
    @(posedge clk);
    #1;
    a[0] = 32'h11; b[0] = 32'h22; sub[0] = 1'b0; start[0] = 1'b1;
    pin_r[0] = 32'h33; pin_c[0] = 1'b0; pin_z[0] = 1'b0; pin_en[0] = 1'b1;
    @(posedge clk);
    #1;
    a[0] = 32'hFF; b[0] = 32'hFF; sub[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 pin_en[0] = 1'b0;

    // START held high on every width
    start = 3'b111;
    repeat (24) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        a[i] = $urandom; b[i] = $urandom; sub[i] = 1'($urandom);
      end
    end
    start = '0;
    repeat (8) @(posedge clk);

    // abort in the first busy cycle
    @(posedge clk);
    #1;
    a[0] = 32'h77; b[0] = 32'h11; sub[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    #2 clr_n = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
    op(0, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0);

    op(1, 32'hF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
    op(1, 32'h5, 32'h2, 1'b1, 32'h3, 1'b1, 1'b0);
    op(1, 32'h2, 32'h5, 1'b1, 32'hD, 1'b0, 1'b0);
    op(1, 32'hA, 32'hA, 1'b1, 32'h0, 1'b1, 1'b1);

    op(2, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b1);
    op(2, 32'h5000, 32'h2000, 1'b1, 32'h3000, 1'b1, 1'b0);
    op(2, 32'h2000, 32'h5000, 1'b1, 32'hD000, 1'b0, 1'b0);
    op(2, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0);

    repeat (400) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        sub[i]   = 1'($urandom);
        a[i]     = $urandom;
        b[i]     = $urandom;
      end
    end
    start = '0;
    repeat (8) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
